pulse_param_loader: RTL

PULSE_PARAM_LOADER -- requirements
Module: pulse_param_loader

---
 rtl/pulse_param_pkg.sv | 22 ++
 rtl/pulse_param_txser.sv | 56 +++++
 rtl/pulse_param_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_param_pkg.sv
// Shared types and constants for the UART pulse-parameter loader.
package pulse_param_pkg;

  typedef enum logic [1:0] {
    ST_RECV      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_SEND      = 2'd2,
    ST_SEND_WAIT = 2'd3
  } state_t;

  localparam logic [6:0] COMMIT_ADDR = 7'h7F;
  localparam int         READ_BIT    = 7;

  // Error replies are the payload checksum inverted; sums start from zero.
  localparam logic [7:0] ERR_XOR  = 8'hFF;
  localparam logic [7:0] SUM_SEED = 8'h00;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pulse_param_txser.sv
// Response serialiser: holds one reply (1..NBYTES bytes) and hands it to the UART byte by byte.
module pulse_param_txser
  import pulse_param_pkg::*;
#(
  parameter int NBYTES = 5,
  parameter int LW     = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NBYTES*8-1:0] load_bytes,
  input  logic [LW-1:0]       load_len,
  input  logic                send_en,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_byte,
  output logic                more
);

  logic [NBYTES*8-1:0] bytes_q, bytes_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       idx_q, idx_d;

  always_comb begin
    tx_start = send_en && !tx_busy;
    more     = (idx_q != len_q);
    tx_byte  = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == LW'(i)) tx_byte = bytes_q[i*8 +: 8];
    end

    bytes_d = bytes_q;
    len_d   = len_q;
    idx_d   = idx_q;
    if (load) begin
      bytes_d = load_bytes;
      len_d   = load_len;
      idx_d   = '0;
    end else if (tx_start) begin
      idx_d = idx_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      bytes_q <= bytes_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// UART-framed loader for a bank of pulse-parameter registers with checksummed replies.
// Define PULSE_PARAM_SHADOW_EN to stage writes in a shadow bank committed by ctrl 0x7F.
module pulse_param_loader
  import pulse_param_pkg::*;
#(
  parameter int                         NREG     = 16,
  parameter int                         DBYTES   = 4,
  parameter int                         TIMEOUT  = 2_000_000,
  parameter logic [NREG*8*DBYTES-1:0]   RST_VALS = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  output logic [NREG*8*DBYTES-1:0]   params,
  output logic [NREG-1:0]            upd,
  output logic                       frame_err
);

  localparam int W    = 8 * DBYTES;
  localparam int CW   = $clog2(DBYTES + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int RMAX = DBYTES + 1;
  localparam int LW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_CTRL = CW'(DBYTES);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
  localparam logic [7:0]    NREG_B   = 8'(NREG);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [LW-1:0] LEN_READ = LW'(RMAX);

  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure, accepted only in
  // RECV; tx_start is a one-cycle request issued only while tx_busy=0, and tx_byte is
  // stable for that cycle. The UART raises tx_busy no later than the cycle after.
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic [W-1:0]        pay_q, pay_d;
  logic [7:0]          ctrl_q, ctrl_d;
  logic                wait_q, wait_d;
  logic [NREG*W-1:0]   params_q, params_d;
  logic [NREG-1:0]     upd_q, upd_d;
  logic                frame_err_q, frame_err_d;
`ifdef PULSE_PARAM_SHADOW_EN
  logic [NREG*W-1:0]   shadow_q, shadow_d;
`endif

  logic                load;
  logic [RMAX*8-1:0]   load_bytes;
  logic [LW-1:0]       load_len;
  logic                send_en;
  logic                tx_more;

  logic [6:0]          addr;
  logic                is_rd;
  logic                addr_ok;
  logic                timed_out;
  logic [7:0]          pay_sum;
  logic [7:0]          reg_sum;
  logic [W-1:0]        reg_sel;

  always_comb begin
    addr      = ctrl_q[6:0];
    is_rd     = ctrl_q[READ_BIT];
    addr_ok   = ({1'b0, addr} < NREG_B);
    timed_out = (cnt_q != '0) && (idle_q == TO_LIMIT);
    pay_sum   = SUM_SEED;
    reg_sum   = SUM_SEED;
    reg_sel   = '0;
    for (int b = 0; b < DBYTES; b++) pay_sum = add8(pay_sum, pay_q[b*8 +: 8]);
    for (int i = 0; i < NREG; i++) begin
      if ({1'b0, addr} == 8'(i)) reg_sel = params_q[i*W +: W];
    end
    for (int b = 0; b < DBYTES; b++) reg_sum = add8(reg_sum, reg_sel[b*8 +: 8]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    pay_d       = pay_q;
    ctrl_d      = ctrl_q;
    wait_d      = wait_q;
    params_d    = params_q;
    upd_d       = '0;
    frame_err_d = 1'b0;
`ifdef PULSE_PARAM_SHADOW_EN
    shadow_d    = shadow_q;
`endif
    load        = 1'b0;
    load_bytes  = '0;
    load_len    = '0;

    case (state_q)
      ST_RECV: begin
        // A byte landing on the expiry cycle still opens the next frame.
        if (timed_out) begin
          frame_err_d = 1'b1;
          idle_d      = '0;
          if (rx_valid) begin
            pay_d[7:0] = rx_byte;
            cnt_d      = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end else if (rx_valid) begin
          idle_d = '0;
          if (cnt_q == CNT_CTRL) begin
            ctrl_d  = rx_byte;
            cnt_d   = '0;
            state_d = ST_DECODE;
          end else begin
            for (int b = 0; b < DBYTES; b++) begin
              if (cnt_q == CW'(b)) pay_d[b*8 +: 8] = rx_byte;
            end
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q != '0) begin
          idle_d = idle_q + TW'(1);
        end
      end

      ST_DECODE: begin
        state_d = ST_SEND;
        load    = 1'b1;
        if (addr_ok && !is_rd) begin
          for (int i = 0; i < NREG; i++) begin
            if ({1'b0, addr} == 8'(i)) begin
`ifdef PULSE_PARAM_SHADOW_EN
              shadow_d[i*W +: W] = pay_q;
`else
              params_d[i*W +: W] = pay_q;
              upd_d[i]           = 1'b1;
`endif
            end
          end
          load_bytes[7:0] = pay_sum;
          load_len        = LEN_ONE;
        end else if (addr_ok) begin
          load_bytes[W-1:0]  = reg_sel;
          load_bytes[W +: 8] = reg_sum;
          load_len           = LEN_READ;
`ifdef PULSE_PARAM_SHADOW_EN
        end else if (!is_rd && (addr == COMMIT_ADDR)) begin
          params_d        = shadow_q;
          upd_d           = '1;
          load_bytes[7:0] = pay_sum;
          load_len        = LEN_ONE;
`endif
        end else begin
          frame_err_d     = 1'b1;
          load_bytes[7:0] = pay_sum ^ ERR_XOR;
          load_len        = LEN_ONE;
        end
      end

      ST_SEND: begin
        if (tx_start) begin
          state_d = ST_SEND_WAIT;
          wait_d  = 1'b1;
        end
      end

      ST_SEND_WAIT: begin
        // The first cycle gives the UART time to raise tx_busy.
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (!tx_busy) begin
          state_d = tx_more ? ST_SEND : ST_RECV;
        end
      end

      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RECV;
      cnt_q       <= '0;
      idle_q      <= '0;
      pay_q       <= '0;
      ctrl_q      <= '0;
      wait_q      <= 1'b0;
      params_q    <= RST_VALS;
      upd_q       <= '0;
      frame_err_q <= 1'b0;
`ifdef PULSE_PARAM_SHADOW_EN
      shadow_q    <= RST_VALS;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      pay_q       <= pay_d;
      ctrl_q      <= ctrl_d;
      wait_q      <= wait_d;
      params_q    <= params_d;
      upd_q       <= upd_d;
      frame_err_q <= frame_err_d;
`ifdef PULSE_PARAM_SHADOW_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  assign send_en   = (state_q == ST_SEND);
  assign params    = params_q;
  assign upd       = upd_q;
  assign frame_err = frame_err_q;

  pulse_param_txser #(
    .NBYTES (RMAX),
    .LW     (LW)
  ) u_txser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_bytes (load_bytes),
    .load_len   (load_len),
    .send_en    (send_en),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .more       (tx_more)
  );

endmodule
